multi_cycle_core: RTL and testbench

Multi-cycle RV32I-subset processor core; the next generation after the single-cycle top. It replaces separate instruction and data memories with one shared memory port that has a valid/ready handshake, so wait-state memories are tolerated. A main-control FSM sequences each instruction over 3–5 cycles. Register count and reset vector are parametrised.

---
 rtl/multi_cycle_core_pkg.sv | 64 ++++++
 rtl/mc_regfile.sv | 41 ++++
 rtl/multi_cycle_core.sv | 262 ++++++++++++++++++++++++++
 tb/tb_multi_cycle_core.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_core_pkg.sv
//------------------------------------------------------------------------------
// multi_cycle_core_pkg
// Shared states, opcode/funct constants and ALU-op decode for multi_cycle_core.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package multi_cycle_core_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_ILLEGAL  = 4'd11
   } state_t;

   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;

   localparam logic [2:0] c_F3_ADD = 3'b000;
   localparam logic [2:0] c_F3_SLT = 3'b010;
   localparam logic [2:0] c_F3_OR  = 3'b110;
   localparam logic [2:0] c_F3_AND = 3'b111;
   localparam logic [6:0] c_F7_SUB = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_t;

   // funct7 only selects subtraction for register-register forms; addi never subtracts.
   function automatic alu_op_t alu_decode(input logic       is_rtype,
                                          input logic [2:0] funct3,
                                          input logic [6:0] funct7);
      alu_op_t op;
      op = ALU_ADD;
      case (funct3)
         c_F3_ADD: op = (is_rtype && (funct7 == c_F7_SUB)) ? ALU_SUB : ALU_ADD;
         c_F3_SLT: op = ALU_SLT;
         c_F3_OR:  op = ALU_OR;
         c_F3_AND: op = ALU_AND;
         default:  op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mc_regfile.sv
//------------------------------------------------------------------------------
// mc_regfile
// Architectural register file: two async read ports, one sync write port.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mc_regfile #(
   parameter int NREGS = 32,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] i_raddr1,
   input  logic [AW-1:0] i_raddr2,
   output logic [31:0]   o_rdata1,
   output logic [31:0]   o_rdata2,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [31:0]   i_wdata
);

   logic [31:0] r_regs [NREGS];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_we && (i_waddr != '0)) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // x0 is hardwired to zero regardless of array contents.
   assign o_rdata1 = (i_raddr1 == '0) ? 32'h0 : r_regs[i_raddr1];
   assign o_rdata2 = (i_raddr2 == '0) ? 32'h0 : r_regs[i_raddr2];

endmodule

`default_nettype wire

// File: rtl/multi_cycle_core.sv
//------------------------------------------------------------------------------
// multi_cycle_core
// Multi-cycle RV32I-subset core with one shared valid/ready memory port.
// Optional trap-on-illegal behaviour: define MULTI_CYCLE_CORE_TRAP_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module multi_cycle_core
   import multi_cycle_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NREGS    = 32
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic        retire,
   output logic        halt
);

   localparam int AW = $clog2(NREGS);

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_pc;
   logic [31:0] r_old_pc;
   logic [31:0] r_ir;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_alu_out;
   logic [31:0] r_mdr;

   logic [6:0]  w_opcode;
   logic [2:0]  w_funct3;
   logic [6:0]  w_funct7;
   logic [31:0] w_imm_i;
   logic [31:0] w_imm_s;
   logic [31:0] w_imm_b;
   logic [31:0] w_imm_j;
   logic [31:0] w_rs1_data;
   logic [31:0] w_rs2_data;
   logic        w_rf_we;
   logic [31:0] w_rf_wdata;
   alu_op_t     w_alu_op;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_result;

   logic        w_mem_req;
   logic        w_mem_we;
   logic [31:0] w_mem_addr;
   logic [31:0] w_mem_wdata;
   logic        w_retire;

   assign w_opcode = r_ir[6:0];
   assign w_funct3 = r_ir[14:12];
   assign w_funct7 = r_ir[31:25];

   assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
   assign w_imm_s = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
   assign w_imm_b = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
   assign w_imm_j = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};

   mc_regfile #(
      .NREGS (NREGS)
   ) u_regfile (
      .clk      (clk),
      .rst      (rst),
      .i_raddr1 (r_ir[15 +: AW]),
      .i_raddr2 (r_ir[20 +: AW]),
      .o_rdata1 (w_rs1_data),
      .o_rdata2 (w_rs2_data),
      .i_we     (w_rf_we),
      .i_waddr  (r_ir[7 +: AW]),
      .i_wdata  (w_rf_wdata)
   );

   always_comb begin
      w_rf_we    = 1'b0;
      w_rf_wdata = r_alu_out;
      case (r_state)
         S_MEMWB: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = r_mdr;
         end
         S_ALUWB: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = r_alu_out;
         end
         S_JAL: begin
            w_rf_we    = 1'b1;
            w_rf_wdata = r_old_pc + 32'd4;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_alu_op     = alu_decode(r_state == S_EXECR, w_funct3, w_funct7);
      w_alu_b      = (r_state == S_EXECR) ? r_b : w_imm_i;
      w_alu_result = r_a + w_alu_b;
      case (w_alu_op)
         ALU_ADD: w_alu_result = r_a + w_alu_b;
         ALU_SUB: w_alu_result = r_a - w_alu_b;
         ALU_AND: w_alu_result = r_a & w_alu_b;
         ALU_OR:  w_alu_result = r_a | w_alu_b;
         ALU_SLT: w_alu_result = {31'd0, $signed(r_a) < $signed(w_alu_b)};
         default: w_alu_result = r_a + w_alu_b;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_addr   = 32'h0;
      w_mem_wdata  = 32'h0;
      w_retire     = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_mem_req  = 1'b1;
            w_mem_addr = r_pc;
            if (mem_ready) w_next_state = S_DECODE;
         end
         S_DECODE: begin
            case (w_opcode)
               c_OP_LOAD, c_OP_STORE: w_next_state = S_MEMADR;
               c_OP_RTYPE:            w_next_state = S_EXECR;
               c_OP_ITYPE:            w_next_state = S_EXECI;
               c_OP_BRANCH:           w_next_state = S_BRANCH;
               c_OP_JAL:              w_next_state = S_JAL;
               default:               w_next_state = S_ILLEGAL;
            endcase
         end
         S_MEMADR: begin
            w_next_state = (w_opcode == c_OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            w_mem_req  = 1'b1;
            w_mem_addr = r_alu_out;
            if (mem_ready) w_next_state = S_MEMWB;
         end
         S_MEMWRITE: begin
            w_mem_req   = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = r_alu_out;
            w_mem_wdata = r_b;
            if (mem_ready) begin
               w_retire     = 1'b1;
               w_next_state = S_FETCH;
            end
         end
         S_EXECR, S_EXECI: begin
            w_next_state = S_ALUWB;
         end
         S_MEMWB, S_ALUWB, S_BRANCH, S_JAL: begin
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
         end
         S_ILLEGAL: begin
`ifdef MULTI_CYCLE_CORE_TRAP_EN
            w_next_state = S_ILLEGAL;
`else
            w_retire     = 1'b1;
            w_next_state = S_FETCH;
`endif
         end
         default: begin
            w_next_state = S_FETCH;
         end
      endcase
      // Outputs are forced quiet while reset is asserted, even mid-handshake.
      if (rst) begin
         w_mem_req   = 1'b0;
         w_mem_we    = 1'b0;
         w_mem_addr  = 32'h0;
         w_mem_wdata = 32'h0;
         w_retire    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc      <= RESET_PC;
         r_old_pc  <= 32'h0;
         r_ir      <= 32'h0;
         r_a       <= 32'h0;
         r_b       <= 32'h0;
         r_alu_out <= 32'h0;
         r_mdr     <= 32'h0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (mem_ready) begin
                  r_ir     <= mem_rdata;
                  r_old_pc <= r_pc;
                  r_pc     <= r_pc + 32'd4;
               end
            end
            S_DECODE: begin
               r_a       <= w_rs1_data;
               r_b       <= w_rs2_data;
               r_alu_out <= r_old_pc + w_imm_b;
            end
            S_MEMADR: begin
               r_alu_out <= r_a + ((w_opcode == c_OP_LOAD) ? w_imm_i : w_imm_s);
            end
            S_MEMREAD: begin
               if (mem_ready) r_mdr <= mem_rdata;
            end
            S_EXECR, S_EXECI: begin
               r_alu_out <= w_alu_result;
            end
            S_BRANCH: begin
               if (r_a == r_b) r_pc <= r_alu_out;
            end
            S_JAL: begin
               r_pc <= r_old_pc + w_imm_j;
            end
            default: ;
         endcase
      end
   end

`ifdef MULTI_CYCLE_CORE_TRAP_EN
   logic r_halt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_halt <= 1'b0;
      end else if (r_state == S_ILLEGAL) begin
         r_halt <= 1'b1;
      end
   end

   assign halt = r_halt;
`else
   assign halt = 1'b0;
`endif

   assign mem_req   = w_mem_req;
   assign mem_we    = w_mem_we;
   assign mem_addr  = w_mem_addr;
   assign mem_wdata = w_mem_wdata;
   assign retire    = w_retire;

endmodule

`default_nettype wire

// File: tb/tb_multi_cycle_core.sv
//------------------------------------------------------------------------------
// tb_multi_cycle_core
// Directed program run against a wait-state memory model for multi_cycle_core.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_cycle_core;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        retire;
   logic        halt;

   multi_cycle_core #(
      .RESET_PC (32'h100),
      .NREGS    (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .retire    (retire),
      .halt      (halt)
   );

   always #5 clk = ~clk;

`ifdef MULTI_CYCLE_CORE_TRAP_EN
   localparam int N_ST = 12;
   localparam int N_F  = 31;
`else
   localparam int N_ST = 13;
   localparam int N_F  = 32;
`endif

   logic [31:0] prog [256];
   logic [31:0] dmem [64];
   int          data_wait = 2;
   int          wcnt = 0;
   int          cyc = 0;
   int          nret = 0;
   int          nfetch = 0;
   int          nst = 0;
   int          ret_cyc [64];
   logic [31:0] fetch_log [64];
   logic [31:0] st_addr [64];
   logic [31:0] st_data [64];
   int          n_stall = 0;
   int          n_stall_bad = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] p_addr = 32'h0;
   logic [31:0] p_wdata = 32'h0;
   logic        p_we = 1'b0;
   int          errors = 0;
   int          checks = 0;

   logic [31:0] exp_fetch [32] = '{
      32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114, 32'h118, 32'h11C,
      32'h120, 32'h124, 32'h128, 32'h12C, 32'h138, 32'h130, 32'h134, 32'h144,
      32'h154, 32'h158, 32'h15C, 32'h160, 32'h164, 32'h168, 32'h16C, 32'h170,
      32'h174, 32'h178, 32'h17C, 32'h180, 32'h184, 32'h188, 32'h18C, 32'h190};
   logic [31:0] exp_st_addr [13] = '{
      32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36,
      32'd40, 32'd44, 32'd48, 32'd52, 32'd56};
   logic [31:0] exp_st_data [13] = '{
      32'd12, 32'd12, 32'hFFFF_FFFE, 32'd0, 32'h148, 32'd1, 32'd0, 32'd15,
      32'd6, 32'd1, 32'd5, 32'd7, 32'd5};

   // Code lives at 0x100 and above with no wait states; data below 0x100 stalls.
   assign mem_ready = (mem_addr >= 32'h100) || (wcnt >= data_wait);
   assign mem_rdata = (mem_addr >= 32'h100) ? prog[mem_addr[9:2]] : dmem[mem_addr[7:2]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst) begin
         wcnt <= 0;
      end else begin
         wcnt <= (!mem_req || mem_ready) ? 0 : wcnt + 1;
         if (retire && nret < 64) begin
            ret_cyc[nret] <= cyc;
            nret          <= nret + 1;
         end
         if (mem_req && mem_ready && !mem_we && mem_addr >= 32'h100 && nfetch < 64) begin
            fetch_log[nfetch] <= mem_addr;
            nfetch            <= nfetch + 1;
         end
         if (mem_req && mem_ready && mem_we) begin
            dmem[mem_addr[7:2]] <= mem_wdata;
            if (nst < 64) begin
               st_addr[nst] <= mem_addr;
               st_data[nst] <= mem_wdata;
               nst          <= nst + 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && mem_req && !mem_ready) begin
         n_stall <= n_stall + 1;
         if (prev_stall && (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
            n_stall_bad <= n_stall_bad + 1;
         prev_stall <= 1'b1;
         p_addr     <= mem_addr;
         p_we       <= mem_we;
         p_wdata    <= mem_wdata;
      end else begin
         prev_stall <= 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] w);
      prog[a[9:2]] = w;
   endtask

   function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] lw_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [4:0] rd);
      return {imm, rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] b_t(input logic [12:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1);
      return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] j_t(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) prog[i] = 32'h0;
      put(32'h100, i_t(12'd5, 5'd0, 3'b000, 5'd1));           // addi x1,x0,5
      put(32'h104, i_t(12'd7, 5'd0, 3'b000, 5'd2));           // addi x2,x0,7
      put(32'h108, r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3));     // add  x3,x1,x2
      put(32'h10C, r_t(7'h20, 5'd2, 5'd1, 3'b000, 5'd4));     // sub  x4,x1,x2
      put(32'h110, r_t(7'h00, 5'd1, 5'd2, 3'b010, 5'd5));     // slt  x5,x2,x1
      put(32'h114, s_t(12'd8, 5'd3, 5'd0));                   // sw   x3,8(x0)
      put(32'h118, lw_t(12'd8, 5'd0, 5'd6));                  // lw   x6,8(x0)
      put(32'h11C, s_t(12'd12, 5'd6, 5'd0));
      put(32'h120, s_t(12'd16, 5'd4, 5'd0));
      put(32'h124, s_t(12'd20, 5'd5, 5'd0));
      put(32'h128, b_t(13'd8, 5'd2, 5'd1));                   // beq x1,x2 (not taken)
      put(32'h12C, j_t(21'd12, 5'd0));                        // jal x0,+12
      put(32'h130, i_t(12'd1, 5'd0, 3'b000, 5'd7));           // addi x7,x0,1
      put(32'h134, j_t(21'd16, 5'd0));                        // jal x0,+16
      put(32'h138, b_t(13'h1FF8, 5'd1, 5'd1));                // beq x1,x1,-8 (taken)
      put(32'h144, j_t(21'd16, 5'd8));                        // jal x8,+16
      put(32'h154, s_t(12'd24, 5'd8, 5'd0));
      put(32'h158, s_t(12'd28, 5'd7, 5'd0));
      put(32'h15C, i_t(12'd5, 5'd0, 3'b000, 5'd0));           // addi x0,x0,5
      put(32'h160, s_t(12'd32, 5'd0, 5'd0));
      put(32'h164, i_t(12'd10, 5'd1, 3'b110, 5'd9));          // ori  x9,x1,10
      put(32'h168, i_t(12'd6, 5'd2, 3'b111, 5'd10));          // andi x10,x2,6
      put(32'h16C, i_t(12'd0, 5'd4, 3'b010, 5'd11));          // slti x11,x4,0
      put(32'h170, r_t(7'h00, 5'd2, 5'd1, 3'b111, 5'd12));    // and  x12,x1,x2
      put(32'h174, r_t(7'h00, 5'd2, 5'd1, 3'b110, 5'd13));    // or   x13,x1,x2
      put(32'h178, s_t(12'd36, 5'd9, 5'd0));
      put(32'h17C, s_t(12'd40, 5'd10, 5'd0));
      put(32'h180, s_t(12'd44, 5'd11, 5'd0));
      put(32'h184, s_t(12'd48, 5'd12, 5'd0));
      put(32'h188, s_t(12'd52, 5'd13, 5'd0));
      put(32'h18C, 32'h0000_007F);                            // unsupported opcode
      put(32'h190, s_t(12'd56, 5'd1, 5'd0));
      put(32'h194, lw_t(12'd60, 5'd0, 5'd14));

      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_req",   32'(mem_req),   32'd0);
      check("rst_we",    32'(mem_we),    32'd0);
      check("rst_addr",  mem_addr,       32'd0);
      check("rst_wdata", mem_wdata,      32'd0);
      check("rst_retire",32'(retire),    32'd0);
      check("rst_halt",  32'(halt),      32'd0);

      @(negedge clk);
      rst = 1'b0;
      #1;
      check("first_req",  32'(mem_req), 32'd1);
      check("first_addr", mem_addr,     32'h100);
      check("first_we",   32'(mem_we),  32'd0);

      for (int k = 0; k < 3000 && nst < N_ST; k++) @(negedge clk);
      #1;
      check("store_count", nst, N_ST);
      check("stall_cycles", n_stall, 2 * (N_ST + 1));
      check("stall_stable", n_stall_bad, 0);
      data_wait = 1000;

      for (int i = 0; i < N_ST; i++) begin
         check($sformatf("st_addr[%0d]", i), st_addr[i], exp_st_addr[i]);
         check($sformatf("st_data[%0d]", i), st_data[i], exp_st_data[i]);
      end
      for (int i = 0; i < N_F; i++)
         check($sformatf("fetch[%0d]", i), fetch_log[i], exp_fetch[i]);

      check("cpi_addi",   ret_cyc[1]  - ret_cyc[0],  4);
      check("cpi_add",    ret_cyc[2]  - ret_cyc[1],  4);
      check("cpi_sw_wait",ret_cyc[5]  - ret_cyc[4],  6);
      check("cpi_lw_wait",ret_cyc[6]  - ret_cyc[5],  7);
      check("cpi_beq_nt", ret_cyc[10] - ret_cyc[9],  3);
      check("cpi_beq_t",  ret_cyc[12] - ret_cyc[11], 3);

`ifdef MULTI_CYCLE_CORE_TRAP_EN
      repeat (20) @(negedge clk);
      #1;
      check("trap_halt",   32'(halt),    32'd1);
      check("trap_req",    32'(mem_req), 32'd0);
      check("trap_retire", nret,         30);
      repeat (30) @(negedge clk);
      #1;
      check("trap_halt_hold", 32'(halt),    32'd1);
      check("trap_req_hold",  32'(mem_req), 32'd0);
      check("trap_nret_hold", nret,         30);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst2_req", 32'(mem_req), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst2_halt", 32'(halt),    32'd0);
      check("rst2_req",  32'(mem_req), 32'd1);
      check("rst2_addr", mem_addr,     32'h100);
`else
      check("nop_cpi",  ret_cyc[30] - ret_cyc[29], 3);
      check("nop_halt", 32'(halt), 32'd0);
      for (int k = 0; k < 100 && !(mem_req && mem_addr == 32'd60); k++) @(negedge clk);
      repeat (3) @(negedge clk);
      #1;
      check("lw_stall_req",  32'(mem_req), 32'd1);
      check("lw_stall_addr", mem_addr,     32'd60);
      check("lw_stall_we",   32'(mem_we),  32'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst2_req",  32'(mem_req), 32'd0);
      check("rst2_addr", mem_addr,     32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("refetch_req",  32'(mem_req), 32'd1);
      check("refetch_addr", mem_addr,     32'h100);
      check("refetch_we",   32'(mem_we),  32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
